// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core: fetch, decode, execute,
// memory and writeback, plus the PC, instruction register, retire counter and trap.
module multicycle_controller #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_im_req,
  output logic [XLEN-1:0] o_im_addr,
  input  logic            i_im_ack,
  input  logic [XLEN-1:0] i_im_rdata,
  output logic [XLEN-1:0] o_ir,
  input  logic [6:0]      i_opcode,
  input  logic [XLEN-1:0] i_next_pc,
  input  logic            i_branch_taken,
  output logic [XLEN-1:0] o_pc,
  output logic            o_dm_req,
  output logic            o_dm_we,
  input  logic            i_dm_ack,
  output logic            o_rf_we,
  output logic            o_illegal,
  output logic [2:0]      o_state,
  output logic [31:0]     o_instret
);

  typedef enum logic [2:0] {
    BOOT      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    TRAP      = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t          r_state;
  state_t          w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] r_ir;
  logic            r_illegal;
  logic [31:0]     r_instret;
  logic            w_ir_load;
  logic            w_retire;
  logic            w_trap;
  logic            w_legal;
  logic            w_is_mem;
  logic            w_is_store;
  logic            w_is_branch;
  logic            w_is_jump;
  logic            w_target_misaligned;

  always_comb begin
    unique case (i_opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: w_legal = 1'b1;
      default:                           w_legal = 1'b0;
    endcase
  end

  assign w_is_store          = (i_opcode == OP_STORE);
  assign w_is_mem            = (i_opcode == OP_LOAD) || w_is_store;
  assign w_is_branch         = (i_opcode == OP_BRANCH);
  assign w_is_jump           = (i_opcode == OP_JAL) || (i_opcode == OP_JALR);
  assign w_target_misaligned = |i_next_pc[1:0];
  assign w_pc_plus4          = r_pc + XLEN'(4);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_load    = 1'b0;
    w_retire     = 1'b0;
    w_trap       = 1'b0;

    unique case (r_state)
      BOOT: w_state_next = FETCH;

      FETCH: begin
        if (i_im_ack) begin
          w_ir_load    = 1'b1;
          w_state_next = DECODE;
        end
      end

      DECODE: begin
        if (!w_legal) begin
          w_trap       = 1'b1;
          w_state_next = TRAP;
        end else begin
          w_state_next = EXECUTE;
        end
      end

      EXECUTE: begin
        if (w_is_mem) begin
          w_state_next = MEMORY;
        end else if (w_is_branch) begin
          if (i_branch_taken && w_target_misaligned) begin
            w_trap       = 1'b1;
            w_state_next = TRAP;
          end else begin
            w_pc_next    = i_branch_taken ? i_next_pc : w_pc_plus4;
            w_retire     = 1'b1;
            w_state_next = FETCH;
          end
        end else begin
          w_state_next = WRITEBACK;
        end
      end

      MEMORY: begin
        if (i_dm_ack) begin
          if (w_is_store) begin
            w_pc_next    = w_pc_plus4;
            w_retire     = 1'b1;
            w_state_next = FETCH;
          end else begin
            w_state_next = WRITEBACK;
          end
        end
      end

      WRITEBACK: begin
        // The register write still happens on a misaligned jump; only the PC
        // update and retirement are suppressed.
        if (w_is_jump && w_target_misaligned) begin
          w_trap       = 1'b1;
          w_state_next = TRAP;
        end else begin
          w_pc_next    = w_is_jump ? i_next_pc : w_pc_plus4;
          w_retire     = 1'b1;
          w_state_next = FETCH;
        end
      end

      TRAP:    w_state_next = TRAP;
      default: w_state_next = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= BOOT;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_ir_load) r_ir      <= i_im_rdata;
      if (w_trap)    r_illegal <= 1'b1;
      if (w_retire)  r_instret <= r_instret + 32'd1;
    end
  end

  // Strobes decode straight from the state register, so they fall with reset.
  assign o_im_req  = (r_state == FETCH);
  assign o_dm_req  = (r_state == MEMORY);
  assign o_dm_we   = (r_state == MEMORY) && w_is_store;
  assign o_rf_we   = (r_state == WRITEBACK);
  assign o_im_addr = r_pc;
  assign o_pc      = r_pc;
  assign o_ir      = r_ir;
  assign o_illegal = r_illegal;
  assign o_state   = r_state;
  assign o_instret = r_instret;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: drives and samples on the falling
// edge, with all expected values hand-computed.
module tb_multicycle_controller;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_im_req;
  logic [31:0] o_im_addr;
  logic        i_im_ack;
  logic [31:0] i_im_rdata;
  logic [31:0] o_ir;
  logic [6:0]  i_opcode;
  logic [31:0] i_next_pc;
  logic        i_branch_taken;
  logic [31:0] o_pc;
  logic        o_dm_req;
  logic        o_dm_we;
  logic        i_dm_ack;
  logic        o_rf_we;
  logic        o_illegal;
  logic [2:0]  o_state;
  logic [31:0] o_instret;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] S_BOOT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXECUTE = 3'd3, S_MEMORY = 3'd4, S_WB = 3'd5,
                         S_TRAP = 3'd6;

  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] LW   = 32'h0000_2103;
  localparam logic [31:0] SW   = 32'h0020_2223;
  localparam logic [31:0] BEQ  = 32'h0000_0463;
  localparam logic [31:0] JAL  = 32'h0000_006F;

  always #5 i_clk = ~i_clk;

  // Instruction decode stand-in: opcode is the low seven IR bits.
  assign i_opcode = o_ir[6:0];

  multicycle_controller dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .o_im_req       (o_im_req),
    .o_im_addr      (o_im_addr),
    .i_im_ack       (i_im_ack),
    .i_im_rdata     (i_im_rdata),
    .o_ir           (o_ir),
    .i_opcode       (i_opcode),
    .i_next_pc      (i_next_pc),
    .i_branch_taken (i_branch_taken),
    .o_pc           (o_pc),
    .o_dm_req       (o_dm_req),
    .o_dm_we        (o_dm_we),
    .i_dm_ack       (i_dm_ack),
    .o_rf_we        (o_rf_we),
    .o_illegal      (o_illegal),
    .o_state        (o_state),
    .o_instret      (o_instret)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  // Entered at a falling edge in FETCH; leaves at a falling edge in DECODE.
  task automatic fetch(input string tag, input logic [31:0] word, input logic [31:0] pc_exp);
    check({tag, "_fetch_state"}, 32'(o_state), 32'(S_FETCH));
    check({tag, "_fetch_addr"}, o_im_addr, pc_exp);
    check({tag, "_fetch_req"}, 32'(o_im_req), 32'd1);
    i_im_ack   = 1'b1;
    i_im_rdata = word;
    tick();
    i_im_ack   = 1'b0;
    i_im_rdata = '0;
    check({tag, "_ir"}, o_ir, word);
    check({tag, "_decode_state"}, 32'(o_state), 32'(S_DECODE));
  endtask

  task automatic check_retired(input string tag, input logic [31:0] pc_exp, input logic [31:0] ret_exp);
    check({tag, "_state"}, 32'(o_state), 32'(S_FETCH));
    check({tag, "_pc"}, o_pc, pc_exp);
    check({tag, "_instret"}, o_instret, ret_exp);
  endtask

  initial begin
    int trap_req_seen;
    i_rst_n        = 1'b0;
    i_im_ack       = 1'b0;
    i_im_rdata     = '0;
    i_next_pc      = '0;
    i_branch_taken = 1'b0;
    i_dm_ack       = 1'b0;
    repeat (2) tick();

    check("rst_state", 32'(o_state), 32'(S_BOOT));
    check("rst_pc", o_pc, 32'h0);
    check("rst_ir", o_ir, 32'h0);
    check("rst_illegal", 32'(o_illegal), 32'd0);
    check("rst_instret", o_instret, 32'd0);
    check("rst_strobes", {28'd0, o_im_req, o_dm_req, o_dm_we, o_rf_we}, 32'd0);

    // ADDI at PC 0 with zero-wait fetch: FETCH again five cycles after release.
    i_rst_n = 1'b1;
    tick();
    fetch("addi", ADDI, 32'h0);
    tick();
    check("addi_exec", 32'(o_state), 32'(S_EXECUTE));
    tick();
    check("addi_wb", 32'(o_state), 32'(S_WB));
    check("addi_rf_we", 32'(o_rf_we), 32'd1);
    tick();
    check("addi_rf_we_drop", 32'(o_rf_we), 32'd0);
    check_retired("addi", 32'h4, 32'd1);

    // LW with data ack in the third MEMORY cycle.
    fetch("lw", LW, 32'h4);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("lw_mem_state", 32'(o_state), 32'(S_MEMORY));
      check("lw_dm_req", 32'(o_dm_req), 32'd1);
      check("lw_dm_we", 32'(o_dm_we), 32'd0);
      check("lw_pc_stable", o_pc, 32'h4);
      if (i == 2) i_dm_ack = 1'b1;
      tick();
    end
    i_dm_ack = 1'b0;
    check("lw_wb", 32'(o_state), 32'(S_WB));
    check("lw_dm_req_drop", 32'(o_dm_req), 32'd0);
    check("lw_rf_we", 32'(o_rf_we), 32'd1);
    tick();
    check_retired("lw", 32'h8, 32'd2);

    // SW, with a stray fetch ack during DECODE that must not touch the IR.
    fetch("sw", SW, 32'h8);
    i_im_ack   = 1'b1;
    i_im_rdata = 32'hDEAD_BEEF;
    tick();
    i_im_ack   = 1'b0;
    check("sw_ir_hold", o_ir, SW);
    check("sw_exec_rf_we", 32'(o_rf_we), 32'd0);
    tick();
    check("sw_mem_state", 32'(o_state), 32'(S_MEMORY));
    check("sw_dm_req", 32'(o_dm_req), 32'd1);
    check("sw_dm_we", 32'(o_dm_we), 32'd1);
    check("sw_rf_we", 32'(o_rf_we), 32'd0);
    i_dm_ack = 1'b1;
    tick();
    i_dm_ack = 1'b0;
    check("sw_rf_we_after", 32'(o_rf_we), 32'd0);
    check_retired("sw", 32'hC, 32'd3);

    // BEQ taken to 0x40, then not taken from 0x40.
    fetch("beq_t", BEQ, 32'hC);
    tick();
    i_branch_taken = 1'b1;
    i_next_pc      = 32'h40;
    check("beq_t_rf_we", 32'(o_rf_we), 32'd0);
    tick();
    i_branch_taken = 1'b0;
    check_retired("beq_t", 32'h40, 32'd4);

    fetch("beq_n", BEQ, 32'h40);
    tick();
    i_next_pc = 32'h80;
    tick();
    check_retired("beq_n", 32'h44, 32'd5);

    // Aligned JAL, then a JAL to a misaligned target.
    fetch("jal", JAL, 32'h44);
    i_next_pc = 32'h100;
    tick();
    tick();
    check("jal_rf_we", 32'(o_rf_we), 32'd1);
    tick();
    check_retired("jal", 32'h100, 32'd6);

    fetch("jal_mis", JAL, 32'h100);
    i_next_pc = 32'h102;
    tick();
    tick();
    check("jal_mis_rf_we", 32'(o_rf_we), 32'd1);
    tick();
    check("jal_mis_state", 32'(o_state), 32'(S_TRAP));
    check("jal_mis_pc", o_pc, 32'h100);
    check("jal_mis_illegal", 32'(o_illegal), 32'd1);
    check("jal_mis_instret", o_instret, 32'd6);

    // All-zero instruction traps; TRAP ignores a fetch ack and stays quiet.
    do_reset();
    check("rst2_illegal", 32'(o_illegal), 32'd0);
    fetch("zero", 32'h0, 32'h0);
    tick();
    check("zero_state", 32'(o_state), 32'(S_TRAP));
    check("zero_illegal", 32'(o_illegal), 32'd1);
    i_im_ack      = 1'b1;
    i_im_rdata    = ADDI;
    trap_req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_im_req || o_dm_req || o_rf_we || o_state != S_TRAP) trap_req_seen++;
      tick();
    end
    i_im_ack = 1'b0;
    check("zero_trap_quiet", 32'(trap_req_seen), 32'd0);
    check("zero_ir_frozen", o_ir, 32'h0);
    check("zero_pc_frozen", o_pc, 32'h0);

    // PC wraps: branch to 0xFFFF_FFFC, then ADDI there.
    do_reset();
    fetch("wrap_b", BEQ, 32'h0);
    tick();
    i_branch_taken = 1'b1;
    i_next_pc      = 32'hFFFF_FFFC;
    tick();
    i_branch_taken = 1'b0;
    check_retired("wrap_b", 32'hFFFF_FFFC, 32'd1);
    fetch("wrap_a", ADDI, 32'hFFFF_FFFC);
    repeat (3) tick();
    check_retired("wrap_a", 32'h0, 32'd2);

    // Taken branch to a misaligned target traps in EXECUTE.
    fetch("beq_mis", BEQ, 32'h0);
    tick();
    i_branch_taken = 1'b1;
    i_next_pc      = 32'h42;
    tick();
    i_branch_taken = 1'b0;
    check("beq_mis_state", 32'(o_state), 32'(S_TRAP));
    check("beq_mis_pc", o_pc, 32'h0);
    check("beq_mis_instret", o_instret, 32'd2);

    // Reset in MEMORY with the data ack still pending.
    do_reset();
    fetch("rstm_a", ADDI, 32'h0);
    repeat (3) tick();
    check_retired("rstm_a", 32'h4, 32'd1);
    fetch("rstm_lw", LW, 32'h4);
    tick();
    tick();
    check("rstm_dm_req", 32'(o_dm_req), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check("rstm_dm_req_drop", 32'(o_dm_req), 32'd0);
    check("rstm_state", 32'(o_state), 32'(S_BOOT));
    check("rstm_pc", o_pc, 32'h0);
    check("rstm_instret", o_instret, 32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    check("rstm_refetch", 32'(o_state), 32'(S_FETCH));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
